// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART image loader that fills i_ram and then releases the CPU
//
// Receives an 8N1 byte stream, parses frames of the form
//   0xA5, LEN_HI, LEN_LO, LEN x {data_hi, data_lo}, CHK
// and writes each 16-bit word to instruction memory. CHK is the mod-256 sum of every
// byte after the sync byte. A checksum-valid frame ends in DONE, which releases the CPU.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   rx           UART receive line (idle high, asynchronous to clk)
//   imem_w_addr  i_ram word write address
//   imem_din     i_ram write data
//   imem_w_en    i_ram write strobe, one cycle per word
//   cpu_hold     1 while the CPU must stay in reset
//   done         image loaded with a matching checksum (sticky until rst)
//   error        last frame was bad (sticky until the next accepted sync byte)
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int IMEM_DEPTH   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] imem_w_addr,
    output logic [15:0] imem_din,
    output logic        imem_w_en,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- 8N1 receiver ----------------
    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_busy;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;   // 0 = start bit, 1..8 = data bits, 9 = stop bit
    logic [7:0]    shift;
    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_busy    <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_sync) begin
                    rx_busy <= 1'b1;
                    clk_cnt <= '0;
                    bit_cnt <= 4'd0;
                end
            end else if (bit_cnt == 4'd0) begin
                // Mid start bit: a high line here means the falling edge was a glitch.
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt <= '0;
                    if (rx_sync) rx_busy <= 1'b0;
                    else         bit_cnt <= 4'd1;
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end else if (clk_cnt != BIT_LAST) begin
                clk_cnt <= clk_cnt + 1'b1;
            end else begin
                clk_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_sync) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shift;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end else begin
                    shift   <= {rx_sync, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

    // ---------------- frame state machine ----------------
    typedef enum logic [2:0] {
        S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t      state, state_n;
    logic [7:0]  sum, sum_n, hi, hi_n;
    logic [15:0] len, len_n, addr, addr_n, waddr_n, din_n;
    logic        w_en_n, done_n, error_n;

    always_comb begin
        state_n = state;
        sum_n   = sum;
        hi_n    = hi;
        len_n   = len;
        addr_n  = addr;
        waddr_n = imem_w_addr;
        din_n   = imem_din;
        w_en_n  = 1'b0;
        done_n  = done;
        error_n = error;
        case (state)
            S_SYNC: if (byte_valid && rx_byte == 8'hA5) begin
                sum_n   = 8'h00;
                addr_n  = 16'h0000;
                error_n = 1'b0;
                state_n = S_LEN_HI;
            end
            S_LEN_HI: if (byte_valid) begin
                hi_n    = rx_byte;
                sum_n   = sum + rx_byte;
                state_n = S_LEN_LO;
            end
            S_LEN_LO: if (byte_valid) begin
                len_n = {hi, rx_byte};
                sum_n = sum + rx_byte;
                if (len_n > 16'(IMEM_DEPTH)) state_n = S_ERR;
                else if (len_n == 16'h0000)  state_n = S_CHECK;
                else                         state_n = S_DATA_HI;
            end
            S_DATA_HI: if (byte_valid) begin
                hi_n    = rx_byte;
                sum_n   = sum + rx_byte;
                state_n = S_DATA_LO;
            end
            S_DATA_LO: if (byte_valid) begin
                sum_n   = sum + rx_byte;
                din_n   = {hi, rx_byte};
                waddr_n = addr;
                w_en_n  = 1'b1;
                addr_n  = addr + 16'd1;
                state_n = (addr_n == len) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: if (byte_valid) begin
                if (rx_byte == sum) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    state_n = S_ERR;
                end
            end
            S_DONE: state_n = S_DONE;
            S_ERR: begin
                error_n = 1'b1;
                state_n = S_SYNC;
            end
            default: state_n = S_SYNC;
        endcase
        // A broken byte inside a frame kills the frame; while hunting for sync it is noise.
        if (frame_err && state != S_SYNC && state != S_DONE) state_n = S_ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_SYNC;
            sum         <= 8'h00;
            hi          <= 8'h00;
            len         <= 16'h0000;
            addr        <= 16'h0000;
            imem_w_addr <= 16'h0000;
            imem_din    <= 16'h0000;
            imem_w_en   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            sum         <= sum_n;
            hi          <= hi_n;
            len         <= len_n;
            addr        <= addr_n;
            imem_w_addr <= waddr_n;
            imem_din    <= din_n;
            imem_w_en   <= w_en_n;
            done        <= done_n;
            error       <= error_n;
        end
    end

    assign cpu_hold = ~done;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader
module tb_uart_boot_loader;
    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];
    typedef logic [31:0] xq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] imem_w_addr, imem_din;
    logic        imem_w_en, cpu_hold, done, error;

    int checks   = 0;
    int failures = 0;
    logic [31:0] wq[$];   // observed writes {addr, data}

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .IMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .imem_w_addr(imem_w_addr), .imem_din(imem_din), .imem_w_en(imem_w_en),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_w_en) wq.push_back({imem_w_addr, imem_din});

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0; idle(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; idle(CPB); end
        rx = stop_bit; idle(CPB);
        rx = 1'b1; idle(6);
    endtask

    task automatic send_range(input bq_t f, input int from, input int to);
        for (int i = from; i < to; i++) send_byte(f[i], 1'b1);
    endtask

    // Frame built from the protocol rules: checksum is the plain sum of everything after 0xA5.
    function automatic bq_t make_frame(input logic [15:0] len, input wq_t w);
        bq_t f;
        int  s;
        f.push_back(8'hA5); f.push_back(len[15:8]); f.push_back(len[7:0]);
        foreach (w[i]) begin f.push_back(w[i][15:8]); f.push_back(w[i][7:0]); end
        s = 0;
        for (int i = 1; i < f.size(); i++) s += int'(f[i]);
        f.push_back(8'(s % 256));
        return f;
    endfunction

    function automatic xq_t expect_writes(input wq_t w);
        xq_t x;
        foreach (w[i]) x.push_back({16'(i), w[i]});
        return x;
    endfunction

    task automatic do_reset();
        rst = 1'b1; rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
        wq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1;
        idle(2);
        checks++; if (imem_w_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0000", imem_w_addr); end
        checks++; if (imem_din !== 16'h0)    begin failures++; $display("FAIL reset_din got=%h exp=0000", imem_din); end
        checks++; if (imem_w_en !== 1'b0)    begin failures++; $display("FAIL reset_wen got=%b exp=0", imem_w_en); end
        checks++; if (cpu_hold !== 1'b1)     begin failures++; $display("FAIL reset_hold got=%b exp=1", cpu_hold); end
        checks++; if (done !== 1'b0)         begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0)        begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        do_reset();
    endtask

    task automatic test_good_frame();
        wq_t w; bq_t f; xq_t x; logic [31:0] got;
        do_reset();
        w = '{16'h1234, 16'hABCD};
        f = make_frame(16'd2, w); x = expect_writes(w);
        send_range(f, 0, f.size());
        checks++; if (wq.size() !== x.size()) begin failures++; $display("FAIL good_wcount got=%0d exp=%0d", wq.size(), x.size()); end
        foreach (x[i]) begin
            got = (i < wq.size()) ? wq[i] : 32'hDEADDEAD;
            checks++; if (got !== x[i]) begin failures++; $display("FAIL good_write%0d got=%h exp=%h", i, got, x[i]); end
        end
        checks++; if (done !== 1'b1)     begin failures++; $display("FAIL good_done got=%b exp=1", done); end
        checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL good_hold got=%b exp=0", cpu_hold); end
        checks++; if (error !== 1'b0)    begin failures++; $display("FAIL good_error got=%b exp=0", error); end
        // Once done, later traffic must be ignored.
        wq.delete();
        w = '{16'h5555};
        f = make_frame(16'd1, w);
        send_range(f, 0, f.size());
        checks++; if (wq.size() !== 0) begin failures++; $display("FAIL after_done_writes got=%0d exp=0", wq.size()); end
        checks++; if (done !== 1'b1)   begin failures++; $display("FAIL after_done_done got=%b exp=1", done); end
    endtask

    task automatic test_bad_checksum();
        wq_t w; bq_t f; logic [31:0] got;
        do_reset();
        w = '{16'h1234};
        f = make_frame(16'd1, w);
        f[f.size()-1] = f[f.size()-1] ^ 8'hFF;
        send_range(f, 0, f.size());
        got = (wq.size() > 0) ? wq[0] : 32'hDEADDEAD;
        checks++; if (wq.size() !== 1)        begin failures++; $display("FAIL badchk_wcount got=%0d exp=1", wq.size()); end
        checks++; if (got !== 32'h0000_1234)  begin failures++; $display("FAIL badchk_write got=%h exp=00001234", got); end
        checks++; if (error !== 1'b1)         begin failures++; $display("FAIL badchk_error got=%b exp=1", error); end
        checks++; if (cpu_hold !== 1'b1)      begin failures++; $display("FAIL badchk_hold got=%b exp=1", cpu_hold); end
        checks++; if (done !== 1'b0)          begin failures++; $display("FAIL badchk_done got=%b exp=0", done); end
        wq.delete();
        w = '{16'h5678};
        f = make_frame(16'd1, w);
        send_range(f, 0, 1);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL resync_error_clear got=%b exp=0", error); end
        send_range(f, 1, f.size());
        got = (wq.size() > 0) ? wq[0] : 32'hDEADDEAD;
        checks++; if (got !== 32'h0000_5678) begin failures++; $display("FAIL resync_write got=%h exp=00005678", got); end
        checks++; if (done !== 1'b1)         begin failures++; $display("FAIL resync_done got=%b exp=1", done); end
    endtask

    task automatic test_len_limit();
        bq_t f; wq_t none;
        do_reset();
        f = '{8'hA5, 8'h00, 8'(DEPTH + 1)};
        send_range(f, 0, f.size());
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL len_over_error got=%b exp=1", error); end
        checks++; if (wq.size() !== 0) begin failures++; $display("FAIL len_over_writes got=%0d exp=0", wq.size()); end
        f = make_frame(16'd0, none);
        send_range(f, 0, f.size());
        checks++; if (done !== 1'b1)   begin failures++; $display("FAIL len_zero_done got=%b exp=1", done); end
        checks++; if (error !== 1'b0)  begin failures++; $display("FAIL len_zero_error got=%b exp=0", error); end
        checks++; if (wq.size() !== 0) begin failures++; $display("FAIL len_zero_writes got=%0d exp=0", wq.size()); end
    endtask

    task automatic test_garbage();
        bq_t g, f; wq_t w; logic [31:0] got;
        do_reset();
        g = '{8'h00, 8'hFF, 8'h5A};
        send_range(g, 0, g.size());
        w = '{16'h0007};
        f = make_frame(16'd1, w);
        send_range(f, 0, f.size());
        got = (wq.size() > 0) ? wq[0] : 32'hDEADDEAD;
        checks++; if (wq.size() !== 1)       begin failures++; $display("FAIL garbage_wcount got=%0d exp=1", wq.size()); end
        checks++; if (got !== 32'h0000_0007) begin failures++; $display("FAIL garbage_write got=%h exp=00000007", got); end
        checks++; if (done !== 1'b1)         begin failures++; $display("FAIL garbage_done got=%b exp=1", done); end
    endtask

    task automatic test_glitch_framing();
        bq_t f; wq_t w; logic [31:0] got;
        // A glitch mid-frame must not be taken as a byte: the frame still loads cleanly.
        do_reset();
        w = '{16'h1234};
        f = make_frame(16'd1, w);
        send_range(f, 0, 3);
        rx = 1'b0; idle(2); rx = 1'b1; idle(20);
        send_range(f, 3, f.size());
        got = (wq.size() > 0) ? wq[0] : 32'hDEADDEAD;
        checks++; if (got !== 32'h0000_1234) begin failures++; $display("FAIL glitch_write got=%h exp=00001234", got); end
        checks++; if (done !== 1'b1)         begin failures++; $display("FAIL glitch_done got=%b exp=1", done); end
        // Glitch then a stop-bit-0 byte during DATA_HI.
        do_reset();
        send_range(f, 0, 3);
        rx = 1'b0; idle(2); rx = 1'b1; idle(20);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL glitch_no_error got=%b exp=0", error); end
        send_byte(8'h12, 1'b0);
        idle(4);
        checks++; if (error !== 1'b1)    begin failures++; $display("FAIL framing_error got=%b exp=1", error); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL framing_hold got=%b exp=1", cpu_hold); end
        checks++; if (wq.size() !== 0)   begin failures++; $display("FAIL framing_writes got=%0d exp=0", wq.size()); end
    endtask

    task automatic test_reset_mid_frame();
        bq_t f; wq_t w; xq_t x; logic [31:0] got;
        do_reset();
        w = '{16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0123};
        f = make_frame(16'd4, w);
        send_range(f, 0, 8);          // sync, len, two words, third high byte
        checks++; if (wq.size() !== 2) begin failures++; $display("FAIL midrst_pre_writes got=%0d exp=2", wq.size()); end
        rx = 1'b0; idle(CPB * 3);     // partway into the third low byte
        #2 rst = 1'b1;
        #1;
        checks++; if (imem_w_addr !== 16'h0) begin failures++; $display("FAIL midrst_addr got=%h exp=0000", imem_w_addr); end
        checks++; if (imem_din !== 16'h0)    begin failures++; $display("FAIL midrst_din got=%h exp=0000", imem_din); end
        checks++; if (cpu_hold !== 1'b1)     begin failures++; $display("FAIL midrst_hold got=%b exp=1", cpu_hold); end
        checks++; if (imem_w_en !== 1'b0)    begin failures++; $display("FAIL midrst_wen got=%b exp=0", imem_w_en); end
        rx = 1'b1;
        idle(3); rst = 1'b0; idle(20);
        wq.delete();
        w = '{16'(($urandom)), 16'(($urandom)), 16'(($urandom))};
        f = make_frame(16'd3, w); x = expect_writes(w);
        send_range(f, 0, f.size());
        foreach (x[i]) begin
            got = (i < wq.size()) ? wq[i] : 32'hDEADDEAD;
            checks++; if (got !== x[i]) begin failures++; $display("FAIL midrst_reload%0d got=%h exp=%h", i, got, x[i]); end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL midrst_done got=%b exp=1", done); end
    endtask

    task automatic test_random_frames();
        bq_t f; wq_t w; xq_t x; int n; logic bad; logic [31:0] got;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            n = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH - 1));
            bad = (it == 3);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            f = make_frame(16'(n), w); x = expect_writes(w);
            if (bad) f[f.size()-1] = f[f.size()-1] + 8'd1;
            send_range(f, 0, f.size());
            checks++; if (wq.size() !== x.size()) begin failures++; $display("FAIL rand%0d_wcount got=%0d exp=%0d", it, wq.size(), x.size()); end
            foreach (x[i]) begin
                got = (i < wq.size()) ? wq[i] : 32'hDEADDEAD;
                checks++; if (got !== x[i]) begin failures++; $display("FAIL rand%0d_write%0d got=%h exp=%h", it, i, got, x[i]); end
            end
            checks++; if (done !== !bad)  begin failures++; $display("FAIL rand%0d_done got=%b exp=%b", it, done, !bad); end
            checks++; if (error !== bad)  begin failures++; $display("FAIL rand%0d_error got=%b exp=%b", it, error, bad); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_len_limit();
        test_garbage();
        test_glitch_framing();
        test_reset_mid_frame();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
